// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// One bit of the operation is processed per clock: shift-add for multiply and
// restoring division for divide. Signed operations run on magnitudes and the
// result signs are fixed up in a final cycle. Every operation, including a
// divide by zero, takes exactly WIDTH+1 cycles from the accepting edge to the
// done pulse.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start, op     begin an operation (00 MULTU, 01 MULT, 10 DIVU, 11 DIV); sampled only when idle
//   a, b          multiplicand/dividend and multiplier/divisor, captured at start
//   hi_we, lo_we  direct writes of wd into HI/LO while idle with no start
//   busy, done    operation in progress / one-cycle pulse when HI/LO take the result
//   hi, lo        HI (product upper half or remainder) and LO (product lower half or quotient)

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isDiv_q, isDiv_d;
    logic             negRes_q, negRes_d;
    logic             negRem_q, negRem_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMag, bMag;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   divDiff;
    logic               divGe;
    logic [2*WIDTH-1:0] prodMag, prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;

    // Operand signs only matter for the signed ops (op[0]); magnitudes feed the
    // unsigned core so one datapath serves all four operations.
    assign aNeg = op[0] & a[WIDTH-1];
    assign bNeg = op[0] & b[WIDTH-1];
    assign aMag = aNeg ? -a : a;
    assign bMag = bNeg ? -b : b;

    // Shift-add step: the multiplier sits in accLo and is consumed LSB first
    // while the partial product shifts down into it.
    assign mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Restoring step: the dividend shifts out of accLo into the partial
    // remainder in accHi and quotient bits shift into accLo. When the subtract
    // succeeds the true difference is below the divisor, so the low WIDTH bits
    // of the wrapped difference are exact.
    assign divShift = {accHi_q, accLo_q[WIDTH-1]};
    assign divGe    = divShift >= {1'b0, opnd_q};
    assign divDiff  = divShift[WIDTH-1:0] - opnd_q;

    // Sign fix-up. A zero divisor leaves the dividend magnitude as remainder,
    // so the dividend-sign fix restores the raw dividend in HI.
    assign prodMag = {accHi_q, accLo_q};
    assign prodFix = negRes_q ? -prodMag : prodMag;
    assign quotFix = negRes_q ? -accLo_q : accLo_q;
    assign remFix  = negRem_q ? -accHi_q : accHi_q;

    // State register and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            accHi_q  <= '0;
            accLo_q  <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            accHi_q  <= accHi_d;
            accLo_q  <= accLo_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: capture in IDLE, iterate in RUN, publish in FINISH.
    // HI/LO change only on a finished result or an idle direct write.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = CW'(WIDTH);
                    isDiv_d  = op[1];
                    negRes_d = aNeg ^ bNeg;
                    negRem_d = aNeg;
                    accHi_d  = '0;
                    accLo_d  = aMag;
                    opnd_d   = bMag;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            RUN: begin
                if (isDiv_q) begin
                    accHi_d = divGe ? divDiff : divShift[WIDTH-1:0];
                    accLo_d = {accLo_q[WIDTH-2:0], divGe};
                end else begin
                    accHi_d = mulSum[WIDTH:1];
                    accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FINISH;
            end
            FINISH: begin
                if (isDiv_q) begin
                    hi_d = remFix;
                    lo_d = (opnd_q == '0) ? '1 : quotFix;
                end else begin
                    hi_d = prodFix[2*WIDTH-1:WIDTH];
                    lo_d = prodFix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
